// File: rtl/chip_protocol_sequencer.sv
// chip_protocol_sequencer
// Stage sequencer for the ChIP chip control-layer pads: LOAD -> MIX -> WASH ->
// COLLECT (-> FLUSH) -> IDLE. All outputs are registered; pad values are
// decoded from the next state so they change on the same edge as `state`.
// Optional feature macro: CHIP_SEQ_FLUSH_EN adds a vent-everything FLUSH
// stage after COLLECT.
module chip_protocol_sequencer #(
    parameter int SIZE         = 2,
    parameter int PUMP_DIV     = 4,
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        inlet_sel,
    input  logic [SIZE-1:0]   ring_mask,
    input  logic [CNT_W-1:0]  load_time,
    input  logic [CNT_W-1:0]  pump_cycles,
    input  logic [CNT_W-1:0]  wash_time,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state,
    output logic [4:0]        pad_ctrl_inlet,
    output logic              pad_ctrl_prep_inlet,
    output logic              pad_ctrl_v1,
    output logic              pad_ctrl_sieve,
    output logic              pad_ctrl_collect,
    output logic [1:0]        pad_ctrl_prep_outlet,
    output logic [SIZE-1:0]   pad_ctrl_ring,
    output logic [2:0]        pad_pump
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_MIX     = 3'd2,
        S_WASH    = 3'd3,
        S_COLLECT = 3'd4,
        S_FLUSH   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(PUMP_DIV - 1);
`ifdef CHIP_SEQ_FLUSH_EN
    localparam logic [CNT_W-1:0] FLUSH_LAST = (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;
`endif

    // A zero duration still occupies one cycle, so the timer reload saturates at 0.
    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [1:0]         phase_q, phase_d;
    logic [CNT_W-1:0]   load_len_q, load_len_d;
    logic [CNT_W-1:0]   pump_len_q, pump_len_d;
    logic [CNT_W-1:0]   wash_len_q, wash_len_d;
    logic [2:0]         sel_q, sel_d;
    logic [SIZE-1:0]    ring_q, ring_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [4:0]         inlet_q, inlet_d;
    logic               prep_in_q, prep_in_d;
    logic               v1_q, v1_d;
    logic               sieve_q, sieve_d;
    logic               collect_q, collect_d;
    logic [1:0]         prep_out_q, prep_out_d;
    logic [SIZE-1:0]    pring_q, pring_d;
    logic [2:0]         pump_q, pump_d;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            pcnt_q     <= '0;
            div_q      <= '0;
            phase_q    <= '0;
            load_len_q <= '0;
            pump_len_q <= '0;
            wash_len_q <= '0;
            sel_q      <= '0;
            ring_q     <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            inlet_q    <= '1;
            prep_in_q  <= 1'b1;
            v1_q       <= 1'b1;
            sieve_q    <= 1'b1;
            collect_q  <= 1'b1;
            prep_out_q <= '1;
            pring_q    <= '1;
            pump_q     <= '1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pcnt_q     <= pcnt_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            load_len_q <= load_len_d;
            pump_len_q <= pump_len_d;
            wash_len_q <= wash_len_d;
            sel_q      <= sel_d;
            ring_q     <= ring_d;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            inlet_q    <= inlet_d;
            prep_in_q  <= prep_in_d;
            v1_q       <= v1_d;
            sieve_q    <= sieve_d;
            collect_q  <= collect_d;
            prep_out_q <= prep_out_d;
            pring_q    <= pring_d;
            pump_q     <= pump_d;
        end
    end

    // Next-state, timers and run-parameter capture.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pcnt_d     = pcnt_q;
        div_d      = div_q;
        phase_d    = phase_q;
        load_len_d = load_len_q;
        pump_len_d = pump_len_q;
        wash_len_d = wash_len_q;
        sel_d      = sel_q;
        ring_d     = ring_q;
        err_d      = err_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (inlet_sel < 3'd5) begin
                        state_d    = S_LOAD;
                        err_d      = 1'b0;
                        load_len_d = load_time;
                        pump_len_d = pump_cycles;
                        wash_len_d = wash_time;
                        sel_d      = inlet_sel;
                        ring_d     = ring_mask;
                        timer_d    = dec_sat(load_time);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (timer_q == '0) begin
                    state_d = S_MIX;
                    pcnt_d  = dec_sat(pump_len_q);
                    phase_d = 2'd0;
                    div_d   = DIV_LAST;
                end else begin
                    timer_d = timer_q - ONE;
                end
            end
            S_MIX: begin
                // Product pump_cycles*3*PUMP_DIV is walked as nested counters
                // (cycle count, phase 0..2, divider) so it cannot overflow.
                if (pump_len_q == '0) begin
                    state_d = S_WASH;
                    timer_d = dec_sat(wash_len_q);
                end else if (div_q != '0) begin
                    div_d = div_q - ONE;
                end else begin
                    div_d = DIV_LAST;
                    if (phase_q != 2'd2) begin
                        phase_d = phase_q + 2'd1;
                    end else begin
                        phase_d = 2'd0;
                        if (pcnt_q == '0) begin
                            state_d = S_WASH;
                            timer_d = dec_sat(wash_len_q);
                        end else begin
                            pcnt_d = pcnt_q - ONE;
                        end
                    end
                end
            end
            S_WASH: begin
                if (timer_q == '0) begin
                    state_d = S_COLLECT;
                    timer_d = dec_sat(load_len_q);
                end else begin
                    timer_d = timer_q - ONE;
                end
            end
            S_COLLECT: begin
                if (timer_q == '0) begin
`ifdef CHIP_SEQ_FLUSH_EN
                    state_d = S_FLUSH;
                    timer_d = FLUSH_LAST;
`else
                    state_d = S_IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    timer_d = timer_q - ONE;
                end
            end
`ifdef CHIP_SEQ_FLUSH_EN
            S_FLUSH: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q - ONE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = err_q;
        end
    end

    // Pad decode from the next state so pads and `state` switch together.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        inlet_d    = '1;
        prep_in_d  = 1'b1;
        v1_d       = 1'b1;
        sieve_d    = 1'b1;
        collect_d  = 1'b1;
        prep_out_d = '1;
        pring_d    = '1;
        pump_d     = '1;

        unique case (state_d)
            S_LOAD: begin
                inlet_d[sel_d] = 1'b0;
                prep_in_d      = 1'b0;
            end
            S_MIX: begin
                v1_d = 1'b0;
                if (pump_len_d != '0) begin
                    unique case (phase_d)
                        2'd0:    pump_d = 3'b011;
                        2'd1:    pump_d = 3'b101;
                        default: pump_d = 3'b110;
                    endcase
                end
            end
            S_WASH: begin
                inlet_d[0]    = 1'b0;
                sieve_d       = 1'b0;
                prep_out_d[0] = 1'b0;
            end
            S_COLLECT: begin
                collect_d     = 1'b0;
                prep_out_d[1] = 1'b0;
                pring_d       = ~ring_d;
            end
            S_FLUSH: begin
                inlet_d    = '0;
                prep_in_d  = 1'b0;
                v1_d       = 1'b0;
                sieve_d    = 1'b0;
                collect_d  = 1'b0;
                prep_out_d = '0;
                pring_d    = '0;
                pump_d     = '0;
            end
            default: begin
            end
        endcase
    end

    assign state                = state_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign err                  = err_q;
    assign pad_ctrl_inlet       = inlet_q;
    assign pad_ctrl_prep_inlet  = prep_in_q;
    assign pad_ctrl_v1          = v1_q;
    assign pad_ctrl_sieve       = sieve_q;
    assign pad_ctrl_collect     = collect_q;
    assign pad_ctrl_prep_outlet = prep_out_q;
    assign pad_ctrl_ring        = pring_q;
    assign pad_pump             = pump_q;

endmodule

// File: tb/tb_chip_protocol_sequencer.sv
// Directed testbench for chip_protocol_sequencer (SIZE=2, PUMP_DIV=4).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, i.e. they reflect the edge just taken.
module tb_chip_protocol_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [2:0]  inlet_sel;
    logic [1:0]  ring_mask;
    logic [15:0] load_time;
    logic [15:0] pump_cycles;
    logic [15:0] wash_time;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  state;
    logic [4:0]  pad_ctrl_inlet;
    logic        pad_ctrl_prep_inlet;
    logic        pad_ctrl_v1;
    logic        pad_ctrl_sieve;
    logic        pad_ctrl_collect;
    logic [1:0]  pad_ctrl_prep_outlet;
    logic [1:0]  pad_ctrl_ring;
    logic [2:0]  pad_pump;

    int unsigned checks   = 0;
    int unsigned failures = 0;

`ifdef CHIP_SEQ_FLUSH_EN
    localparam int FLUSH_LEN = 8;
`else
    localparam int FLUSH_LEN = 0;
`endif

    localparam logic [15:0] ALL1 = 16'hFFFF;

    chip_protocol_sequencer #(
        .SIZE(2),
        .PUMP_DIV(4),
        .CNT_W(16),
        .FLUSH_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .inlet_sel(inlet_sel),
        .ring_mask(ring_mask),
        .load_time(load_time),
        .pump_cycles(pump_cycles),
        .wash_time(wash_time),
        .busy(busy),
        .done(done),
        .err(err),
        .state(state),
        .pad_ctrl_inlet(pad_ctrl_inlet),
        .pad_ctrl_prep_inlet(pad_ctrl_prep_inlet),
        .pad_ctrl_v1(pad_ctrl_v1),
        .pad_ctrl_sieve(pad_ctrl_sieve),
        .pad_ctrl_collect(pad_ctrl_collect),
        .pad_ctrl_prep_outlet(pad_ctrl_prep_outlet),
        .pad_ctrl_ring(pad_ctrl_ring),
        .pad_pump(pad_pump)
    );

    always #5 clk = ~clk;

    // {inlet[4:0], prep_inlet, v1, sieve, collect, prep_outlet[1:0], ring[1:0], pump[2:0]}
    logic [15:0] pads;
    assign pads = {pad_ctrl_inlet, pad_ctrl_prep_inlet, pad_ctrl_v1, pad_ctrl_sieve,
                   pad_ctrl_collect, pad_ctrl_prep_outlet, pad_ctrl_ring, pad_pump};

    function automatic logic [15:0] mk(input logic [4:0] inl, input logic pi, input logic v1,
                                       input logic sv, input logic col, input logic [1:0] po,
                                       input logic [1:0] rg, input logic [2:0] pm);
        return {inl, pi, v1, sv, col, po, rg, pm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        inlet_sel = 3'd0; ring_mask = 2'b00;
        load_time = '0; pump_cycles = '0; wash_time = '0;
        tick(); tick();
        checks++;
        if (pads !== ALL1) begin
            failures++; $display("FAIL reset_pads got=%h want=%h", pads, ALL1);
        end
        checks++;
        if ({state, busy, done, err} !== 6'b000000) begin
            failures++; $display("FAIL reset_status got=%b want=000000", {state, busy, done, err});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        int total;
        logic [2:0]  es;
        logic [15:0] ep;
        logic [2:0]  pm;
        total = 31 + FLUSH_LEN;
        inlet_sel = 3'd2; ring_mask = 2'b10;
        load_time = 16'd2; pump_cycles = 16'd2; wash_time = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Later changes must not affect the run in progress.
        load_time = 16'd9; pump_cycles = 16'd5; wash_time = 16'd7;
        for (int i = 0; i <= total + 1; i++) begin
            if (i < 2) begin
                es = 3'd1; ep = mk(5'b11011, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 3'b111);
            end else if (i < 26) begin
                case (((i - 2) / 4) % 3)
                    0:       pm = 3'b011;
                    1:       pm = 3'b101;
                    default: pm = 3'b110;
                endcase
                es = 3'd2; ep = mk(5'b11111, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 2'b11, pm);
            end else if (i < 29) begin
                es = 3'd3; ep = mk(5'b11110, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b11, 3'b111);
            end else if (i < 31) begin
                es = 3'd4; ep = mk(5'b11111, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 3'b111);
            end else if (i < total) begin
                es = 3'd5; ep = 16'h0000;
            end else begin
                es = 3'd0; ep = ALL1;
            end
            checks++;
            if (state !== es) begin
                failures++; $display("FAIL nom_state i=%0d got=%0d want=%0d", i, state, es);
            end
            checks++;
            if (pads !== ep) begin
                failures++; $display("FAIL nom_pads i=%0d got=%h want=%h", i, pads, ep);
            end
            checks++;
            if ({busy, done} !== {(i < total), (i == total)}) begin
                failures++;
                $display("FAIL nom_busy_done i=%0d got=%b want=%b", i, {busy, done},
                         {(i < total), (i == total)});
            end
            // Start pulses while busy (mid-MIX, and mid-FLUSH when present) are ignored.
            start = (i == 10) || (FLUSH_LEN > 0 && i == 33);
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_bad_select();
        bit seen;
        inlet_sel = 3'd5;
        load_time = '0; pump_cycles = '0; wash_time = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({err, state, done, busy} !== 6'b1_000_0_0) begin
            failures++; $display("FAIL bad_sel got=%b want=100000", {err, state, done, busy});
        end
        tick();
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL bad_sel_sticky got=%b want=1", err);
        end
        inlet_sel = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({err, state} !== 4'b0_001) begin
            failures++; $display("FAIL good_sel got=%b want=0001", {err, state});
        end
        checks++;
        if (pad_ctrl_inlet !== 5'b11110) begin
            failures++; $display("FAIL good_sel_inlet got=%b want=11110", pad_ctrl_inlet);
        end
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            seen = done;
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL good_sel_done timeout got=0 want=1");
        end
        tick();
    endtask

    task automatic test_abort_mix();
        bit any_done;
        // start together with abort in IDLE: abort wins.
        inlet_sel = 3'd1; ring_mask = 2'b01;
        load_time = 16'd2; pump_cycles = 16'd2; wash_time = 16'd3;
        start = 1'b1; abort = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if ({state, busy} !== 4'b000_0) begin
            failures++; $display("FAIL start_abort got=%b want=0000", {state, busy});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        // Index 0..1 LOAD, MIX starts at index 2; 5th MIX cycle is index 6.
        for (int i = 1; i <= 6; i++) tick();
        checks++;
        if ({state, pad_pump} !== {3'd2, 3'b101}) begin
            failures++; $display("FAIL abort_pre got=%b want=010101", {state, pad_pump});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({state, busy, done} !== 5'b000_0_0) begin
            failures++; $display("FAIL abort_status got=%b want=00000", {state, busy, done});
        end
        checks++;
        if (pads !== ALL1) begin
            failures++; $display("FAIL abort_pads got=%h want=%h", pads, ALL1);
        end
        any_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            any_done |= done;
        end
        checks++;
        if (any_done !== 1'b0) begin
            failures++; $display("FAIL abort_no_done got=1 want=0");
        end
    endtask

    task automatic test_zero_durations();
        logic [2:0] es;
        inlet_sel = 3'd3; ring_mask = 2'b11;
        load_time = '0; pump_cycles = '0; wash_time = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 4 + FLUSH_LEN; i++) begin
            es = (i < 4) ? 3'(i + 1) : (i < 4 + FLUSH_LEN) ? 3'd5 : 3'd0;
            checks++;
            if (state !== es) begin
                failures++; $display("FAIL zero_state i=%0d got=%0d want=%0d", i, state, es);
            end
            if (i < 4) begin
                checks++;
                if (pad_pump !== 3'b111) begin
                    failures++; $display("FAIL zero_pump i=%0d got=%b want=111", i, pad_pump);
                end
            end
            checks++;
            if (done !== (i == 4 + FLUSH_LEN)) begin
                failures++;
                $display("FAIL zero_done i=%0d got=%b want=%b", i, done, (i == 4 + FLUSH_LEN));
            end
            tick();
        end
    endtask

    task automatic test_reset_midrun();
        inlet_sel = 3'd4; ring_mask = 2'b10;
        load_time = 16'd5; pump_cycles = 16'd1; wash_time = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst_n = 1'b0; start = 1'b1; abort = 1'b0;
        tick();
        checks++;
        if ({state, busy, done, err} !== 6'b000000 || pads !== ALL1) begin
            failures++;
            $display("FAIL reset_midrun got=%b/%h want=000000/%h", {state, busy, done, err}, pads, ALL1);
        end
        rst_n = 1'b1; start = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_select();
        test_abort_mix();
        test_zero_durations();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
